line_buf_taps: RTL and testbench
================================

Name: line_buf_taps

Overview:
- Parametrised multi-channel shift-register line buffer for the CNN datapath; successor to the fixed 16-deep, 12-bit, single-output buffer.
- Each channel holds a DEPTH-entry shift chain and exposes TAPS evenly spaced tap points, so one block feeds a conv window column for several feature-map channels.
- Adds a fill counter, a window-valid flag and a synchronous clear, so the downstream MAC array knows when tap data is meaningful.

Parameters:
- DATA_W, 12, signed sample width.
- CH, 2, number of independent channels sharing shift_en.
- TAPS, 4, tap points per channel.
- TAP_STRIDE, 4, entries between adjacent taps.
- DEPTH, TAPS*TAP_STRIDE (16), entries per channel. Derived; not overridable.

Ports:
- clk_i  in  1  clock, all logic on the rising edge.
- rst_i  in  1  synchronous reset, active-high.
- clear_i  in  1  synchronous flush of fill state (frame/row start).
- shift_en  in  1  accept data_i and shift all channels one entry.
- data_i  in  CH*DATA_W  channel c in bits [c*DATA_W +: DATA_W], signed.
- data_o  out  CH*DATA_W  oldest entry, register[0], per channel.
- taps_o  out  CH*TAPS*DATA_W  tap k of channel c at [(c*TAPS+k)*DATA_W +: DATA_W], equal to register[k*TAP_STRIDE].
- fill_o  out  $clog2(DEPTH+1)  accepted samples since reset/clear, saturating at DEPTH.
- full_o  out  1  high when fill_o == DEPTH.

Behaviour:
- Storage per channel: register[0..DEPTH-1].
- On shift_en: register[DEPTH-1] <= data_i, and register[i] <= register[i+1] for i < DEPTH-1. Entry 0 is the oldest sample.
- Without shift_en: storage holds. No bypass; data_i never appears combinationally on any output.
- Latency: a sample accepted at edge N is at register[DEPTH-1] after edge N. It reaches register[0] / data_o after DEPTH accepted shifts.
- data_o and taps_o are pure selects of registered storage; no extra pipeline stage.
- fill_o:
  - 0 after reset or clear.
  - +1 per accepted shift while below DEPTH; saturates at DEPTH.
  - full_o is a registered compare, high from the edge that accepts the DEPTH-th sample.
- Once full, further shifts keep full_o high and slide the window by one sample per shift.
- Priority: rst_i > clear_i > shift_en.
  - clear_i with shift_en in the same cycle: the sample is discarded and fill_o = 0.
  - clear_i does not zero storage unless ZERO_PAD_EN is defined.
- Reset mid-fill: identical to clear. Storage handling is governed by the macro.
- Arithmetic: none on data; sign is preserved bit-exactly. fill_o width must represent DEPTH exactly (5 bits for 16).
- Elaboration check: TAPS >= 1, TAP_STRIDE >= 1, CH >= 1.

Optional Feature:
- ZERO_PAD_EN defined:
  - rst_i and clear_i also zero every storage entry in all channels.
  - Taps read 0 until real data shifts in, giving implicit zero padding at row/frame start.
- ZERO_PAD_EN undefined:
  - Storage has no reset (smaller, SRL-inferable).
  - Tap values are don't-care while full_o is low; consumers must gate on full_o.
  - fill_o/full_o behave identically in both builds.

Decomposition:
- lbuf_pkg holds DATA_W_DEF = 12, typedef logic signed [DATA_W_DEF-1:0] sample_t, and a function computing fill width from DEPTH.
- Sub-module lbuf_chan: one channel's DEPTH-entry chain plus tap select, instantiated CH times in a generate loop.
- The fill counter and full_o live once in the top, shared by all channels.

Test Plan:
- Fill: after reset, push ch0 = 0..15 and ch1 = -1..-16 (shift_en every cycle).
  - fill_o counts 1..16; full_o rises on the edge accepting the 16th sample.
  - ch0 taps = 0,4,8,12 and data_o ch0 = 0; ch1 taps = -1,-5,-9,-13.
- Slide: one more shift with ch0 = 16 → ch0 taps = 1,5,9,13, fill_o stays 16, full_o stays 1.
- Gaps: fill with shift_en toggling 1,0,1,0 → storage and fill_o unchanged on idle cycles; full_o after the 16th accepted sample (32 cycles).
- Clear collision: clear_i and shift_en together at fill_o = 7 → fill_o = 0, sample dropped; next shift gives fill_o = 1.
- Reset mid-fill: rst_i at fill_o = 10 → fill_o = 0, full_o = 0.
  - With ZERO_PAD_EN: all taps = 0 next cycle.
  - Without ZERO_PAD_EN: bench ignores taps until full_o.
- Extremes: push 0x7FF and 0x800 (−2048) through the full depth → values emerge at data_o unchanged, sign intact.

Source files
------------

// File: rtl/lbuf_pkg.sv
// Shared types and sizing helpers for the line_buf_taps line buffer.
package lbuf_pkg;

  localparam int DATA_W_DEF = 12;

  typedef logic signed [DATA_W_DEF-1:0] sample_t;

  // Width needed to hold every fill count from 0 up to and including depth.
  function automatic int lbuf_fill_w(input int depth);
    return $clog2(depth + 1);
  endfunction

endpackage

// File: rtl/lbuf_chan.sv
// One channel: DEPTH-entry shift chain with TAPS evenly spaced read points; no latency beyond storage.
// ZERO_PAD_EN makes reset/clear zero the chain; otherwise storage is unreset and only clock-enabled.
module lbuf_chan
  import lbuf_pkg::*;
#(
  parameter int DATA_W     = DATA_W_DEF,
  parameter int TAPS       = 4,
  parameter int TAP_STRIDE = 4,
  localparam int DEPTH     = TAPS * TAP_STRIDE
) (
  input  logic                   clk_i,
  input  logic                   rst_i,
  input  logic                   clear_i,
  input  logic                   shift_i,
  input  logic [DATA_W-1:0]      data_i,
  output logic [DATA_W-1:0]      data_o,
  output logic [TAPS*DATA_W-1:0] taps_o
);

  logic [DATA_W-1:0] sr_q [DEPTH];
  logic [DATA_W-1:0] sr_d [DEPTH];
  logic              shift_ok;

  // Reset and clear both win over a same-cycle shift, so the sample is dropped.
  assign shift_ok = shift_i & ~clear_i & ~rst_i;

  always_comb begin
    for (int i = 0; i < DEPTH - 1; i++) begin
      sr_d[i] = sr_q[i+1];
    end
    sr_d[DEPTH-1] = data_i;
  end

`ifdef ZERO_PAD_EN
  always_ff @(posedge clk_i) begin
    if (rst_i || clear_i) begin
      for (int i = 0; i < DEPTH; i++) begin
        sr_q[i] <= '0;
      end
    end else if (shift_ok) begin
      sr_q <= sr_d;
    end
  end
`else
  always_ff @(posedge clk_i) begin
    if (shift_ok) begin
      sr_q <= sr_d;
    end
  end
`endif

  assign data_o = sr_q[0];

  for (genvar k = 0; k < TAPS; k++) begin : g_tap
    assign taps_o[k*DATA_W +: DATA_W] = sr_q[k*TAP_STRIDE];
  end

endmodule

// File: rtl/line_buf_taps.sv
// Multi-channel tapped line buffer with shared fill counter; taps are direct register selects, no stall path.
// ZERO_PAD_EN: reset/clear also zero all storage so taps read 0 until real data arrives.
module line_buf_taps
  import lbuf_pkg::*;
#(
  parameter int DATA_W     = DATA_W_DEF,
  parameter int CH         = 2,
  parameter int TAPS       = 4,
  parameter int TAP_STRIDE = 4,
  localparam int DEPTH     = TAPS * TAP_STRIDE,
  localparam int FILL_W    = lbuf_fill_w(TAPS * TAP_STRIDE)
) (
  input  logic                        clk_i,
  input  logic                        rst_i,
  input  logic                        clear_i,
  input  logic                        shift_en,
  input  logic [CH*DATA_W-1:0]        data_i,
  output logic [CH*DATA_W-1:0]        data_o,
  output logic [CH*TAPS*DATA_W-1:0]   taps_o,
  output logic [FILL_W-1:0]           fill_o,
  output logic                        full_o
);

  if (TAPS < 1 || TAP_STRIDE < 1 || CH < 1) begin : g_bad_cfg
    $error("line_buf_taps: TAPS, TAP_STRIDE and CH must all be >= 1");
  end

  logic [FILL_W-1:0] fill_q, fill_d;
  logic              full_q, full_d;

  always_comb begin
    fill_d = fill_q;
    if (clear_i) begin
      fill_d = '0;
    end else if (shift_en && (fill_q != FILL_W'(DEPTH))) begin
      fill_d = fill_q + FILL_W'(1);
    end
    full_d = (fill_d == FILL_W'(DEPTH));
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      fill_q <= '0;
      full_q <= 1'b0;
    end else begin
      fill_q <= fill_d;
      full_q <= full_d;
    end
  end

  assign fill_o = fill_q;
  assign full_o = full_q;

  for (genvar c = 0; c < CH; c++) begin : g_chan
    lbuf_chan #(
      .DATA_W     (DATA_W),
      .TAPS       (TAPS),
      .TAP_STRIDE (TAP_STRIDE)
    ) u_chan (
      .clk_i   (clk_i),
      .rst_i   (rst_i),
      .clear_i (clear_i),
      .shift_i (shift_en),
      .data_i  (data_i[c*DATA_W +: DATA_W]),
      .data_o  (data_o[c*DATA_W +: DATA_W]),
      .taps_o  (taps_o[c*TAPS*DATA_W +: TAPS*DATA_W])
    );
  end

endmodule

// File: tb/tb_line_buf_taps.sv
// Bench for line_buf_taps: vector table, directed corner sequences and a random run against a queue model.
`timescale 1ns/1ps
module tb_line_buf_taps;
  import lbuf_pkg::*;

  localparam int CH    = 2;
  localparam int TAPS  = 4;
  localparam int STR   = 4;
  localparam int DEPTH = TAPS * STR;
  localparam int W     = DATA_W_DEF;

  logic                    clk = 1'b0;
  logic                    rst = 1'b0;
  logic                    clr = 1'b0;
  logic                    sh  = 1'b0;
  logic [CH*W-1:0]         din = '0;
  logic [CH*W-1:0]         dout;
  logic [CH*TAPS*W-1:0]    taps;
  logic [4:0]              fill;
  logic                    full;

  line_buf_taps dut (
    .clk_i    (clk),
    .rst_i    (rst),
    .clear_i  (clr),
    .shift_en (sh),
    .data_i   (din),
    .data_o   (dout),
    .taps_o   (taps),
    .fill_o   (fill),
    .full_o   (full)
  );

  always #5 clk = ~clk;

  int      tests = 0;
  int      fails = 0;
  int      mfill = 0;
  sample_t q0[$];
  sample_t q1[$];

  typedef struct {
    logic    r;
    logic    c;
    logic    s;
    sample_t d0;
    sample_t d1;
    int      efill;
    logic    efull;
  } vec_t;

  vec_t tbl [18];

  task automatic chk(input string nm, input int act, input int exp);
    tests++;
    if (act != exp) begin
      fails++;
      $display("FAIL %s: got %0d, expected %0d", nm, act, exp);
    end
  endtask

  function automatic int tap_of(input int c, input int k);
    sample_t v;
    v = sample_t'(taps[(c*TAPS+k)*W +: W]);
    return int'(v);
  endfunction

  function automatic int dout_of(input int c);
    sample_t v;
    v = sample_t'(dout[c*W +: W]);
    return int'(v);
  endfunction

  task automatic zero_model();
    q0.delete();
    q1.delete();
    for (int i = 0; i < DEPTH; i++) begin
      q0.push_back('0);
      q1.push_back('0);
    end
  endtask

  // Model: each queue is the window oldest-first; register[i] is element i.
  task automatic model_update(input logic r, input logic c, input logic s,
                              input sample_t d0, input sample_t d1);
    if (r || c) begin
      mfill = 0;
`ifdef ZERO_PAD_EN
      zero_model();
`endif
    end else if (s) begin
      q0.push_back(d0);
      q1.push_back(d1);
      void'(q0.pop_front());
      void'(q1.pop_front());
      if (mfill < DEPTH) mfill++;
    end
  endtask

  task automatic model_check();
    logic data_known;
    chk("fill", int'(fill), mfill);
    chk("full", int'(full), (mfill == DEPTH) ? 1 : 0);
`ifdef ZERO_PAD_EN
    data_known = 1'b1;
`else
    data_known = (mfill == DEPTH);
`endif
    if (data_known) begin
      chk("data_o ch0", dout_of(0), int'(q0[0]));
      chk("data_o ch1", dout_of(1), int'(q1[0]));
      for (int k = 0; k < TAPS; k++) begin
        chk($sformatf("tap ch0 k%0d", k), tap_of(0, k), int'(q0[k*STR]));
        chk($sformatf("tap ch1 k%0d", k), tap_of(1, k), int'(q1[k*STR]));
      end
    end
  endtask

  task automatic step(input logic r, input logic c, input logic s,
                      input sample_t d0, input sample_t d1);
    rst = r;
    clr = c;
    sh  = s;
    din = {d1, d0};
    @(posedge clk);
    model_update(r, c, s, d0, d1);
    #1;
    model_check();
  endtask

  initial begin
    zero_model();
    #2;

    tbl[0] = '{1'b1, 1'b0, 1'b0, sample_t'(0), sample_t'(0), 0, 1'b0};
    for (int i = 1; i <= DEPTH; i++) begin
      tbl[i] = '{1'b0, 1'b0, 1'b1, sample_t'(i - 1), sample_t'(-i), i, (i == DEPTH)};
    end
    tbl[17] = '{1'b0, 1'b0, 1'b1, sample_t'(16), sample_t'(-17), 16, 1'b1};

    // Fill from reset: fill counts 1..16, full on the 16th accepted sample.
    for (int i = 0; i < 17; i++) begin
      step(tbl[i].r, tbl[i].c, tbl[i].s, tbl[i].d0, tbl[i].d1);
      chk($sformatf("vec%0d fill", i), int'(fill), tbl[i].efill);
      chk($sformatf("vec%0d full", i), int'(full), int'(tbl[i].efull));
    end
    for (int k = 0; k < TAPS; k++) begin
      chk($sformatf("filled ch0 tap%0d", k), tap_of(0, k), 4 * k);
      chk($sformatf("filled ch1 tap%0d", k), tap_of(1, k), -1 - 4 * k);
    end
    chk("filled ch0 data_o", dout_of(0), 0);
    chk("filled ch1 data_o", dout_of(1), -1);

    // Slide one sample once full.
    step(tbl[17].r, tbl[17].c, tbl[17].s, tbl[17].d0, tbl[17].d1);
    chk("slide fill", int'(fill), tbl[17].efill);
    chk("slide full", int'(full), int'(tbl[17].efull));
    for (int k = 0; k < TAPS; k++) begin
      chk($sformatf("slide ch0 tap%0d", k), tap_of(0, k), 4 * k + 1);
    end

    // Gapped fill: shift_en alternates, idle cycles must hold everything.
    step(1'b1, 1'b0, 1'b0, '0, '0);
    for (int i = 0; i < 32; i++) begin
      step(1'b0, 1'b0, (i % 2 == 0), sample_t'(100 + i), sample_t'(-100 - i));
      if (i == 29) chk("gap full before 16th", int'(full), 0);
    end
    chk("gap full after 32 cycles", int'(full), 1);
    chk("gap fill after 32 cycles", int'(fill), 16);

    // Clear colliding with shift at fill 7: sample dropped, count restarts.
    step(1'b1, 1'b0, 1'b0, '0, '0);
    for (int i = 0; i < 7; i++) step(1'b0, 1'b0, 1'b1, sample_t'(i), sample_t'(i));
    chk("pre-clear fill", int'(fill), 7);
    step(1'b0, 1'b1, 1'b1, sample_t'(55), sample_t'(55));
    chk("clear collision fill", int'(fill), 0);
    chk("clear collision full", int'(full), 0);
    step(1'b0, 1'b0, 1'b1, sample_t'(56), sample_t'(56));
    chk("post-clear fill", int'(fill), 1);

    // Reset mid-fill at 10.
    for (int i = 0; i < 9; i++) step(1'b0, 1'b0, 1'b1, sample_t'(200 + i), sample_t'(-200 - i));
    chk("pre-reset fill", int'(fill), 10);
    step(1'b1, 1'b0, 1'b1, sample_t'(9), sample_t'(9));
    chk("mid reset fill", int'(fill), 0);
    chk("mid reset full", int'(full), 0);
`ifdef ZERO_PAD_EN
    for (int k = 0; k < TAPS; k++) begin
      chk($sformatf("zero pad ch0 tap%0d", k), tap_of(0, k), 0);
      chk($sformatf("zero pad ch1 tap%0d", k), tap_of(1, k), 0);
    end
`endif

    // Extremes travel the full depth unchanged, sign intact.
    step(1'b0, 1'b0, 1'b1, sample_t'(12'h7FF), sample_t'(12'h800));
    step(1'b0, 1'b0, 1'b1, sample_t'(12'h800), sample_t'(12'h7FF));
    for (int i = 0; i < DEPTH - 2; i++) step(1'b0, 1'b0, 1'b1, sample_t'(1), sample_t'(-1));
    chk("extreme ch0 max", dout_of(0), 2047);
    chk("extreme ch1 min", dout_of(1), -2048);
    step(1'b0, 1'b0, 1'b1, sample_t'(3), sample_t'(3));
    chk("extreme ch0 min", dout_of(0), -2048);
    chk("extreme ch1 max", dout_of(1), 2047);

    // Random traffic with occasional clear/reset.
    for (int i = 0; i < 800; i++) begin
      step(($urandom_range(0, 79) == 0), ($urandom_range(0, 29) == 0),
           ($urandom_range(0, 3) != 0), sample_t'($urandom), sample_t'($urandom));
    end

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
